// File: rtl/fetch_pkg.sv
// Shared types for the program-counter / fetch stage.
// PC width, branch offset width and FSM state encoding.
package fetch_pkg;

    localparam int PC_W     = 12;
    localparam int BR_OFF_W = 8;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: increment, absolute or relative branch.
// All arithmetic wraps modulo 2^D.
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int D = PC_W
) (
    input  logic [D-1:0]        pc,
    input  logic                br_taken,
    input  logic                br_abs,
    input  logic [D-1:0]        br_target,
    input  logic [BR_OFF_W-1:0] br_offset,
    output logic [D-1:0]        pc_nxt
);

    logic [D-1:0] off_ext;

    assign off_ext = {{(D-BR_OFF_W){br_offset[BR_OFF_W-1]}}, br_offset};

    always_comb begin
        pc_nxt = pc + D'(1);
        unique case (1'b1)
            br_taken && br_abs:  pc_nxt = br_target;
            br_taken && !br_abs: pc_nxt = pc + off_ext;
            default:             pc_nxt = pc + D'(1);
        endcase
    end

endmodule

// File: rtl/pc_fetch.sv
// PC and fetch sequencer: start / run / done FSM driving the ROM address.
// Optional run-cycle watchdog enabled by defining PC_WATCHDOG_EN.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter int D          = PC_W,
    parameter int START_ADDR = 0,
    parameter int TIMEOUT    = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                halt,
    input  logic                br_taken,
    input  logic                br_abs,
    input  logic [D-1:0]        br_target,
    input  logic [BR_OFF_W-1:0] br_offset,
    output logic [D-1:0]        prog_ctr,
    output logic                running,
    output logic                done,
    output logic                timeout
);

    localparam logic [D-1:0] START_PC = D'(START_ADDR);

    pc_state_t    state;
    logic [D-1:0] pc_nxt;
    logic         wd_hit;
    logic         halt_eff;

    assign halt_eff = halt && !stall;

    pc_next_calc #(
        .D(D)
    ) u_next (
        .pc        (prog_ctr),
        .br_taken  (br_taken),
        .br_abs    (br_abs),
        .br_target (br_target),
        .br_offset (br_offset),
        .pc_nxt    (pc_nxt)
    );

`ifdef PC_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [15:0] run_cnt;

    assign wd_hit = (state == RUN) && (run_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset || start) begin
            run_cnt <= '0;
            timeout <= 1'b0;
        end else if (state == RUN) begin
            run_cnt <= run_cnt + 16'd1;
            if (wd_hit && !halt_eff)
                timeout <= 1'b1;
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || start) begin
            state    <= IDLE;
            prog_ctr <= START_PC;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: begin
                    // halt beats the watchdog so a clean finish never reports timeout
                    if (halt_eff || wd_hit) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (!stall) begin
                        prog_ctr <= pc_nxt;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch.
// Define PC_WATCHDOG_EN to exercise the watchdog with TIMEOUT=16.
module tb_pc_fetch;

`ifdef PC_WATCHDOG_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif

    logic        clk = 1'b0;
    logic        reset, start, stall, halt;
    logic        br_taken, br_abs;
    logic [11:0] br_target;
    logic [7:0]  br_offset;
    logic [11:0] prog_ctr;
    logic        running, done, timeout;

    int n_cmp = 0;
    int n_err = 0;

    pc_fetch #(
        .D(12),
        .START_ADDR(0),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stall     (stall),
        .halt      (halt),
        .br_taken  (br_taken),
        .br_abs    (br_abs),
        .br_target (br_target),
        .br_offset (br_offset),
        .prog_ctr  (prog_ctr),
        .running   (running),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        stall     = 1'b0;
        halt      = 1'b0;
        br_taken  = 1'b0;
        br_abs    = 1'b0;
        br_target = 12'h000;
        br_offset = 8'h00;
    endtask

    task automatic restart();
        idle_in();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic jump(input logic [11:0] t);
        br_taken  = 1'b1;
        br_abs    = 1'b1;
        br_target = t;
        tick();
        idle_in();
    endtask

    task automatic test_reset();
        idle_in();
        start = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        n_cmp += 4;
        if (prog_ctr !== 12'h000) begin
            n_err++;
            $display("FAIL reset_pc got=%h exp=000", prog_ctr);
        end
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL reset_running got=%b exp=0", running);
        end
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        if (timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_timeout got=%b exp=0", timeout);
        end
        reset = 1'b0;
    endtask

    task automatic test_start_branch();
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (prog_ctr !== 12'h000 || running !== 1'b0) begin
                n_err++;
                $display("FAIL start_hold pc=%h run=%b exp pc=000 run=0",
                         prog_ctr, running);
            end
        end
        start = 1'b0;
        tick();
        n_cmp++;
        if (prog_ctr !== 12'h000 || running !== 1'b1) begin
            n_err++;
            $display("FAIL first_run pc=%h run=%b exp pc=000 run=1",
                     prog_ctr, running);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (prog_ctr !== 12'(i) || running !== 1'b1) begin
                n_err++;
                $display("FAIL seq pc=%h run=%b exp pc=%h run=1",
                         prog_ctr, running, 12'(i));
            end
        end
        jump(12'h040);
        n_cmp++;
        if (prog_ctr !== 12'h040) begin
            n_err++;
            $display("FAIL br_abs got=%h exp=040", prog_ctr);
        end
        br_taken  = 1'b1;
        br_abs    = 1'b0;
        br_offset = 8'hFD;
        tick();
        idle_in();
        n_cmp++;
        if (prog_ctr !== 12'h03D) begin
            n_err++;
            $display("FAIL br_rel got=%h exp=03D", prog_ctr);
        end
    endtask

    task automatic test_stall();
        restart();
        jump(12'h007);
        stall     = 1'b1;
        halt      = 1'b1;
        br_taken  = 1'b1;
        br_abs    = 1'b1;
        br_target = 12'h123;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (prog_ctr !== 12'h007 || running !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL stall pc=%h run=%b done=%b exp pc=007 run=1 done=0",
                         prog_ctr, running, done);
            end
        end
        idle_in();
        tick();
        n_cmp++;
        if (prog_ctr !== 12'h008) begin
            n_err++;
            $display("FAIL stall_release got=%h exp=008", prog_ctr);
        end
    endtask

    task automatic test_wrap();
        restart();
        jump(12'hFFF);
        n_cmp++;
        if (prog_ctr !== 12'hFFF) begin
            n_err++;
            $display("FAIL wrap_set got=%h exp=FFF", prog_ctr);
        end
        tick();
        n_cmp++;
        if (prog_ctr !== 12'h000) begin
            n_err++;
            $display("FAIL wrap_inc got=%h exp=000", prog_ctr);
        end
        tick();
        br_taken  = 1'b1;
        br_abs    = 1'b0;
        br_offset = 8'hFE;
        tick();
        idle_in();
        n_cmp++;
        if (prog_ctr !== 12'hFFF) begin
            n_err++;
            $display("FAIL wrap_rel1 got=%h exp=FFF", prog_ctr);
        end
        jump(12'h002);
        br_taken  = 1'b1;
        br_offset = 8'hFD;
        tick();
        idle_in();
        n_cmp++;
        if (prog_ctr !== 12'hFFF) begin
            n_err++;
            $display("FAIL wrap_rel2 got=%h exp=FFF", prog_ctr);
        end
        br_taken  = 1'b1;
        br_offset = 8'h7F;
        tick();
        idle_in();
        n_cmp++;
        if (prog_ctr !== 12'h07E) begin
            n_err++;
            $display("FAIL rel_pos got=%h exp=07E", prog_ctr);
        end
    endtask

    task automatic test_halt();
        restart();
        jump(12'h009);
        halt      = 1'b1;
        br_taken  = 1'b1;
        br_abs    = 1'b1;
        br_target = 12'h100;
        tick();
        idle_in();
        n_cmp++;
        if (done !== 1'b1 || prog_ctr !== 12'h009 || running !== 1'b0
            || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL halt done=%b pc=%h run=%b to=%b exp done=1 pc=009 run=0 to=0",
                     done, prog_ctr, running, timeout);
        end
        for (int i = 0; i < 10; i++) begin
            br_taken  = i[0];
            br_abs    = i[1];
            br_target = 12'h100;
            br_offset = 8'h10;
            stall     = i[2];
            tick();
            n_cmp++;
            if (done !== 1'b1 || prog_ctr !== 12'h009) begin
                n_err++;
                $display("FAIL done_hold done=%b pc=%h exp done=1 pc=009",
                         done, prog_ctr);
            end
        end
        idle_in();
        start = 1'b1;
        tick();
        n_cmp++;
        if (done !== 1'b0 || prog_ctr !== 12'h000 || running !== 1'b0) begin
            n_err++;
            $display("FAIL done_exit done=%b pc=%h run=%b exp done=0 pc=000 run=0",
                     done, prog_ctr, running);
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        tick();
        tick();
        tick();
        n_cmp++;
        if (prog_ctr !== 12'h002 || running !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre pc=%h run=%b exp pc=002 run=1",
                     prog_ctr, running);
        end
        start = 1'b1;
        tick();
        n_cmp++;
        if (prog_ctr !== 12'h000 || running !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort pc=%h run=%b done=%b exp pc=000 run=0 done=0",
                     prog_ctr, running, done);
        end
        start = 1'b0;
    endtask

    task automatic test_watchdog();
        restart();
        br_taken  = 1'b1;
        br_abs    = 1'b1;
        br_target = 12'h000;
`ifdef PC_WATCHDOG_EN
        for (int i = 0; i < 15; i++) tick();
        n_cmp++;
        if (running !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL wd_pre run=%b done=%b to=%b exp run=1 done=0 to=0",
                     running, done, timeout);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || timeout !== 1'b1 || running !== 1'b0) begin
            n_err++;
            $display("FAIL wd_fire done=%b to=%b run=%b exp done=1 to=1 run=0",
                     done, timeout, running);
        end
        idle_in();
        start = 1'b1;
        tick();
        n_cmp++;
        if (timeout !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL wd_clear to=%b done=%b exp 0 0", timeout, done);
        end
        start = 1'b0;
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            n_cmp++;
            if (running !== 1'b1 || done !== 1'b0 || timeout !== 1'b0
                || prog_ctr !== 12'h000) begin
                n_err++;
                $display("FAIL loop run=%b done=%b to=%b pc=%h exp 1 0 0 000",
                         running, done, timeout, prog_ctr);
            end
        end
        idle_in();
`endif
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        idle_in();
        test_reset();
        test_start_branch();
        test_stall();
        test_wrap();
        test_halt();
        test_back_to_back();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program-counter and fetch-sequencing stage directly upstream of the instruction ROM; drives the ROM address `prog_ctr` every cycle.
- Owns program start, sequential advance, taken branches (absolute or PC-relative), stall holds and program termination.
- Reports `done` to the test harness.

Parameters:
- D, 12, program-counter width; must match the ROM address width.
- START_ADDR, 0, address of the first instruction executed after a start pulse.
- TIMEOUT, 4096, RUN-cycle limit for the optional watchdog.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  held high by harness to load/hold the program; run begins on first cycle low
- stall  input  1  from decode/datapath; freeze PC this cycle
- halt  input  1  decode saw the DONE instruction at current `prog_ctr`
- br_taken  input  1  branch resolved taken this cycle
- br_abs  input  1  1 = absolute target, 0 = PC-relative
- br_target  input  D  absolute target address (from branch LUT)
- br_offset  input  8  signed two's-complement relative offset
- prog_ctr  output  D  instruction ROM address
- running  output  1  high while in RUN
- done  output  1  program finished; level, held until next start
- timeout  output  1  watchdog fired; 0 when WATCHDOG_EN undefined

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: state=IDLE, `prog_ctr`=START_ADDR, `running`=0, `done`=0, `timeout`=0, run counter=0.
- All outputs are registered. ROM data for `prog_ctr` is combinational, so no fetch bubble.
- States: IDLE, RUN, DONE.
- Priority each cycle: reset > start > stall > halt > br_taken > increment.
- start=1 in any state:
  - next state IDLE; `prog_ctr`=START_ADDR; `done`=0; `timeout`=0; counter cleared.
  - A start asserted mid-RUN aborts the run.
- IDLE with start=0: next state RUN; `prog_ctr` stays START_ADDR. The instruction at START_ADDR is presented during the first RUN cycle.
- RUN:
  - stall=1: hold `prog_ctr`; ignore halt and branch inputs.
  - halt=1: go to DONE; `prog_ctr` held at the DONE instruction's address.
  - br_taken=1, br_abs=1: `prog_ctr` <= br_target.
  - br_taken=1, br_abs=0: `prog_ctr` <= `prog_ctr` + sign-extended br_offset, modulo 2^D.
  - otherwise: `prog_ctr` <= `prog_ctr` + 1, modulo 2^D.
- Wrap-around: 2^D−1 +1 → 0. A relative branch below 0 wraps (e.g. 2 + (−3) → 2^D−1). No error is flagged.
- br_target and br_offset are ignored when br_taken=0.
- br_abs is only sampled with br_taken.
- DONE: `done`=1 and `prog_ctr` held. Stall, halt and branch inputs are ignored. Exit only via start.
- `running` = (state==RUN), registered with the state.
- halt and br_taken together: halt wins; no branch is taken.

Optional Feature:
- Macro: PC_WATCHDOG_EN.
- Defined:
  - A 16-bit counter increments on every RUN cycle, stalled cycles included.
  - When the counter reaches TIMEOUT−1 while still in RUN, the next state is DONE with `done`=1 and `timeout`=1.
  - A halt in that same cycle also goes to DONE but leaves `timeout`=0.
  - Counter and `timeout` clear on reset or start.
- Undefined: no counter is built and `timeout` is tied 0.

Decomposition:
- Package `fetch_pkg`:
  - `pc_state_t` enum (IDLE, RUN, DONE).
  - PC_W localparam default 12.
  - BR_OFF_W = 8.
  - The `pc_t` typedef.
- Sub-module `pc_next_calc`: purely combinational next-PC mux/adder (increment, absolute, relative with sign extension). The FSM and registers stay in `pc_fetch`.

Test Plan:
- Reset, then start high 3 cycles, then low → `prog_ctr`=0 through first RUN cycle, then 1,2,3 on successive cycles; `running`=1 from first RUN cycle.
- At `prog_ctr`=5, br_taken=1, br_abs=1, br_target=12'h040 → next `prog_ctr`=0x040. At `prog_ctr`=0x040, br_abs=0, br_offset=8'hFD (−3) → 0x03D.
- At `prog_ctr`=7, stall=1 for 2 cycles with br_taken=1 and halt=1 asserted → `prog_ctr` stays 7 both cycles, state stays RUN. Release stall with only increment → 8.
- Force `prog_ctr`=0xFFF via absolute branch, then increment → 0x000. At `prog_ctr`=1, br_offset=−2 → 0xFFF.
- halt at `prog_ctr`=9 → `done`=1 next cycle, `prog_ctr` held 9 for 10 cycles despite branch pulses. Start pulse → `done`=0, `prog_ctr`=0, IDLE.
- PC_WATCHDOG_EN with TIMEOUT=16 and a tight loop branching to itself → `done`=1 and `timeout`=1 after exactly 16 RUN cycles. Without the macro, the same stimulus stays in RUN indefinitely and `timeout`=0.
